// File: rtl/mul_arb_pkg.sv
// Shared types, widths and the round-robin pointer helper for the shared-multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF   = 6;
    localparam int unsigned PROD_W_DEF  = 2 * WIDTH_DEF;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned ID_MAX_W    = 3;
    localparam int unsigned STAT_W      = 16;
    // Product columns whose partial-product bits the approximate multiplier drops.
    localparam int unsigned APPROX_COLS = 2;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [ID_MAX_W-1:0]  id;
    } op_t;

    typedef struct packed {
        logic [PROD_W_DEF-1:0] data;
        logic [ID_MAX_W-1:0]   id;
    } rsp_t;

    function automatic logic [ID_MAX_W-1:0] rr_next(input logic [ID_MAX_W-1:0] ptr,
                                                    input logic [ID_MAX_W-1:0] win,
                                                    input logic                hs,
                                                    input int unsigned         n);
        if (!hs) begin
            return ptr;
        end
        return (32'(win) == n - 1) ? '0 : win + 1'b1;
    endfunction

endpackage

// File: rtl/if_multiplier.sv
// Connection bundle between the arbiter and the shared combinational multiplier.
interface if_multiplier #(
    parameter int unsigned W = 6
);
    logic [W-1:0]   in1;
    logic [W-1:0]   in2;
    logic [2*W-1:0] out;
    logic           overflow;

    modport mul  (input in1, input in2, output out, output overflow);
    modport host (output in1, output in2, input out, input overflow);
endinterface

// File: rtl/mul_approx_dadda.sv
// Combinational approximate multiplier: partial-product bits in the lowest APPROX_COLS columns
// are dropped before reduction, the rest are summed exactly.
module mul_approx_dadda
    import mul_arb_pkg::*;
#(
    parameter int unsigned W = WIDTH_DEF
) (
    if_multiplier.mul muif
);

    localparam int unsigned PW = 2 * W;
    localparam logic [PW-1:0] KEEP = {{(PW - APPROX_COLS){1'b1}}, {APPROX_COLS{1'b0}}};

    logic [PW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            acc = acc + (({{W{1'b0}}, muif.in2 & {W{muif.in1[i]}}} << i) & KEEP);
        end
    end

    assign muif.out      = acc;
    // A full-width product cannot overflow.
    assign muif.overflow = 1'b0;

endmodule

// File: rtl/mul_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module mul_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    win,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one approximate multiplier over a 2-stage valid/ready pipeline.
// Define MUL_ARB_STATS_EN to add grant_cnt/stall_cnt saturating counters. WIDTH must equal WIDTH_DEF.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned PROD_W  = 2 * WIDTH,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [PROD_W-1:0]          rsp_data,
    output logic [ID_W-1:0]            rsp_id
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]  grant_cnt,
    output logic [STAT_W-1:0]          stall_cnt
`endif
);

    op_t             op_q, op_d;
    rsp_t            rsp_q, rsp_d;
    logic            op_valid_q, rsp_valid_q;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] win;
    logic            any_valid, advance, accept, hs;
    logic            unused_ovf;

    if_multiplier #(.W(WIDTH)) muif ();

    mul_approx_dadda #(.W(WIDTH)) u_mul (
        .muif (muif)
    );

    mul_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .win       (win),
        .any_valid (any_valid)
    );

    assign muif.in1   = op_q.a;
    assign muif.in2   = op_q.b;
    assign unused_ovf = muif.overflow;

    always_comb begin
        advance   = op_valid_q & (~rsp_valid_q | rsp_ready);
        accept    = ~op_valid_q | advance;
        hs        = ~rst & any_valid & accept;
        req_ready = hs ? (NUM_REQ'(1) << win) : '0;

        op_d.a  = req_a[win*WIDTH +: WIDTH];
        op_d.b  = req_b[win*WIDTH +: WIDTH];
        op_d.id = ID_MAX_W'(win);

        rsp_d.data = muif.out;
        rsp_d.id   = op_q.id;

        rr_ptr_d = ID_W'(rr_next(ID_MAX_W'(rr_ptr_q), ID_MAX_W'(win), hs, NUM_REQ));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            op_valid_q  <= 1'b0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            // Operand stage refills on the same edge it drains.
            if (hs) begin
                op_q       <= op_d;
                op_valid_q <= 1'b1;
            end else if (accept) begin
                op_valid_q <= 1'b0;
            end
            if (advance) begin
                rsp_q       <= rsp_d;
                rsp_valid_q <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = PROD_W'(rsp_q.data);
    assign rsp_id    = ID_W'(rsp_q.id);

`ifdef MUL_ARB_STATS_EN
    logic [STAT_W-1:0] grant_q [NUM_REQ];
    logic [STAT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (hs && grant_q[win] != '1) begin
                grant_q[win] <= grant_q[win] + 1'b1;
            end
            if (rsp_valid_q && !rsp_ready && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant
        assign grant_cnt[g*STAT_W +: STAT_W] = grant_q[g];
    end
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (4 requesters, 6-bit operands).
module tb_mul_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 6;
    localparam int PW = 12;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*W-1:0]  req_a = '0;
    logic [NR*W-1:0]  req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [PW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;
`ifdef MUL_ARB_STATS_EN
    logic [NR*16-1:0] grant_cnt;
    logic [15:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mul_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef MUL_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int r, input int a, input int b);
        req_a[r*W +: W] = W'(a);
        req_b[r*W +: W] = W'(b);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        tick();
        settle();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 12'd0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b d=%0d id=%0d want 0/0/0", rsp_valid, rsp_data, rsp_id);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd0 || dut.op_valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ptr=%0d opv=%b want 0/0", dut.rr_ptr_q, dut.op_valid_q);
        end
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        rsp_ready = 1'b1;
        set_op(0, 5, 7);
        req_valid = 4'b0001;
        settle();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got rsp_valid=%b want 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 12'd32 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_rsp: got v=%b d=%0d id=%0d want 1/32/0", rsp_valid, rsp_data, rsp_id);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        logic [IW-1:0] exp_id;
        logic [PW-1:0] exp_data;
        apply_reset();
        rsp_ready = 1'b1;
        for (int r = 0; r < NR; r++) set_op(r, 4, r + 1);
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            settle();
            exp_rdy = NR'(1 << (k % 4));
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
            end
            if (k == 1) begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_latency: got rsp_valid=%b want 0", rsp_valid);
                end
            end
            if (k >= 2) begin
                exp_id   = IW'((k - 2) % 4);
                exp_data = PW'(4 * ((k - 2) % 4 + 1));
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%0d want 1/%0d/%0d",
                             k, rsp_valid, rsp_id, rsp_data, exp_id, exp_data);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [3:0] vld  [12] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
                                  4'b1010, 4'b1010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] erdy [12] = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic       rdy  [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic       erv  [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int         eid  [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 3, 1, 3, 0};
        int         edat [12] = '{0, 0, 36, 36, 36, 36, 36, 36, 40, 24, 56, 0};
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            req_valid = vld[k];
            rsp_ready = rdy[k];
            if (k == 0) set_op(1, 4, 9); else set_op(1, 12, 2);
            if (k < 2) set_op(3, 8, 5); else set_op(3, 8, 7);
            settle();
            checks++;
            if (req_ready !== erdy[k]) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b want %b", k, req_ready, erdy[k]);
            end
            checks++;
            if (rsp_valid !== erv[k]) begin
                errors++;
                $display("FAIL bp_valid[%0d]: got %b want %b", k, rsp_valid, erv[k]);
            end else if (erv[k]) begin
                checks++;
                if (rsp_id !== IW'(eid[k]) || rsp_data !== PW'(edat[k])) begin
                    errors++;
                    $display("FAIL bp_rsp[%0d]: got id=%0d d=%0d want %0d/%0d",
                             k, rsp_id, rsp_data, eid[k], edat[k]);
                end
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_boundary();
        int ea [5] = '{63, 0, 63, 1, 5};
        int eb [5] = '{63, 63, 0, 1, 7};
        int ep [5] = '{3964, 0, 0, 0, 32};
        apply_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin
                set_op(2, ea[k], eb[k]);
                req_valid = 4'b0100;
            end else begin
                req_valid = '0;
            end
            settle();
            if (k < 5) begin
                checks++;
                if (req_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL bnd_ready[%0d]: got %b want 0100", k, req_ready);
                end
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== PW'(ep[k-2])) begin
                    errors++;
                    $display("FAIL bnd_rsp[%0d]: got v=%b id=%0d d=%0d want 1/2/%0d",
                             k - 2, rsp_valid, rsp_id, rsp_data, ep[k-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        for (int r = 0; r < NR; r++) set_op(r, 4, r + 1);
        req_valid = 4'b1111;
        settle();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ready0: got %b want 0001", req_ready);
        end
        tick();
        settle();
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_ready1: got %b want 0010", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_full: got v=%b rdy=%b want 1/0000", rsp_valid, req_ready);
        end
        rst = 1'b1;
        settle();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b want 0000", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 12'd0 || dut.rr_ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL mid_cleared: got v=%b d=%0d ptr=%0d want 0/0/0",
                     rsp_valid, rsp_data, dut.rr_ptr_q);
        end
        rst       = 1'b0;
        rsp_ready = 1'b1;
        settle();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first_grant: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: got rsp_valid=%b want 0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 12'd4) begin
            errors++;
            $display("FAIL mid_rsp: got v=%b id=%0d d=%0d want 1/0/4", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

`ifdef MUL_ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        rsp_ready = 1'b1;
        set_op(2, 4, 3);
        req_valid = 4'b0100;
        tick();
        tick();
        tick();
        req_valid = '0;
        tick();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (grant_cnt[2*16 +: 16] !== 16'd3 || grant_cnt[0 +: 16] !== 16'd0) begin
            errors++;
            $display("FAIL stats_grant: got g2=%0d g0=%0d want 3/0",
                     grant_cnt[2*16 +: 16], grant_cnt[0 +: 16]);
        end
        checks++;
        if (stall_cnt !== 16'd4) begin
            errors++;
            $display("FAIL stats_stall: got %0d want 4", stall_cnt);
        end
        rsp_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_reset_midflight();
`ifdef MUL_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
